fb_write_scheduler: RTL and testbench

Sequences all pixel writes into the framebuffer pixel-write port. It round-robin arbitrates NUM_REQ requesters, such as raster units, using a valid/ready handshake. It also runs a built-in clear engine that sweeps every pixel with a latched clear color. It sits between the raster pipeline and the framebuffer, and drives the framebuffer's pixel write-enable, x, y and color inputs from registers.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/fb_write_scheduler.sv | 157 +++++++++++++++
 tb/tb_fb_write_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types and defaults for the pixel-write path.
package fb_pkg;

  localparam int unsigned SCREEN_WIDTH_DEFAULT  = 640;
  localparam int unsigned SCREEN_HEIGHT_DEFAULT = 480;
  localparam int unsigned COLOR_WIDTH_DEFAULT   = 32;
  localparam int unsigned COORD_WIDTH           = 10;

  typedef logic [COORD_WIDTH-1:0] coord_t;

  // Default-width write record for blocks that carry whole pixel writes.
  typedef struct packed {
    coord_t                         x;
    coord_t                         y;
    logic [COLOR_WIDTH_DEFAULT-1:0] color;
  } pix_wr_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_sched_state_e;

  function automatic logic coord_in_range(coord_t x, coord_t y, int unsigned w, int unsigned h);
    return (32'(x) < w) && (32'(y) < h);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PtrWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic [PtrWidth-1:0] idx;
  logic                found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = PtrWidth'((32'(ptr_q) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PtrWidth'((32'(idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: round-robin requester writes plus a full-screen clear sweep.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEFAULT,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEFAULT,
  parameter int unsigned COLOR_WIDTH   = COLOR_WIDTH_DEFAULT,
  parameter int unsigned NUM_REQ       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_clear_start,
  input  logic [COLOR_WIDTH-1:0]         i_clear_color,
  output logic                           o_clear_busy,
  output logic                           o_clear_done,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*COORD_WIDTH-1:0] i_req_x,
  input  logic [NUM_REQ*COORD_WIDTH-1:0] i_req_y,
  input  logic [NUM_REQ*COLOR_WIDTH-1:0] i_req_color,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_pixel_we,
  output logic [COORD_WIDTH-1:0]         o_pixel_x,
  output logic [COORD_WIDTH-1:0]         o_pixel_y,
  output logic [COLOR_WIDTH-1:0]         o_pixel_color
);

  localparam coord_t LastX = COORD_WIDTH'(SCREEN_WIDTH - 1);
  localparam coord_t LastY = COORD_WIDTH'(SCREEN_HEIGHT - 1);

  fb_sched_state_e state_q, state_d;

  logic                   clear_active;
  logic                   start_accept;
  logic                   req_block;
  logic                   clear_last;
  coord_t                 clr_x_q, clr_y_q;
  logic [COLOR_WIDTH-1:0] clear_color_q;

  logic [NUM_REQ-1:0]     arb_req;
  logic [NUM_REQ-1:0]     gnt;
  logic                   req_fire;
  coord_t                 sel_x, sel_y;
  logic [COLOR_WIDTH-1:0] sel_color;
  logic                   sel_in_range;

  logic                   pix_we_q;
  coord_t                 pix_x_q, pix_y_q;
  logic [COLOR_WIDTH-1:0] pix_color_q;
  logic                   done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (i_clear_start) state_d = CLEAR;
      CLEAR: if (clear_last) state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_active = 1'b0;
    start_accept = 1'b0;
    unique case (state_q)
      IDLE:  start_accept = i_clear_start;
      CLEAR: clear_active = 1'b1;
    endcase
  end

  assign clear_last = (clr_x_q == LastX) && (clr_y_q == LastY);

  // A starting or running clear owns the port, so requesters see no grant at all.
  assign req_block = clear_active | start_accept;
  assign arb_req   = req_block ? '0 : i_req_valid;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .advance(req_fire),
    .gnt    (gnt)
  );

  assign o_req_ready = gnt;
  assign req_fire    = |gnt;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_x     = i_req_x[COORD_WIDTH*k +: COORD_WIDTH];
        sel_y     = i_req_y[COORD_WIDTH*k +: COORD_WIDTH];
        sel_color = i_req_color[COLOR_WIDTH*k +: COLOR_WIDTH];
      end
    end
  end

  assign sel_in_range = coord_in_range(sel_x, sel_y, SCREEN_WIDTH, SCREEN_HEIGHT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_we_q      <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_color_q   <= '0;
      done_q        <= 1'b0;
      clr_x_q       <= '0;
      clr_y_q       <= '0;
      clear_color_q <= '0;
    end else begin
      pix_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (start_accept) begin
        clear_color_q <= i_clear_color;
        clr_x_q       <= '0;
        clr_y_q       <= '0;
      end
      if (clear_active) begin
        pix_we_q    <= 1'b1;
        pix_x_q     <= clr_x_q;
        pix_y_q     <= clr_y_q;
        pix_color_q <= clear_color_q;
        done_q      <= clear_last;
        if (clr_x_q == LastX) begin
          clr_x_q <= '0;
          clr_y_q <= clr_y_q + 1'b1;
        end else begin
          clr_x_q <= clr_x_q + 1'b1;
        end
      end else if (req_fire && sel_in_range) begin
        // Off-screen writes complete the handshake but leave the port untouched.
        pix_we_q    <= 1'b1;
        pix_x_q     <= sel_x;
        pix_y_q     <= sel_y;
        pix_color_q <= sel_color;
      end
    end
  end

  assign o_clear_busy  = clear_active;
  assign o_clear_done  = done_q;
  assign o_pixel_we    = pix_we_q;
  assign o_pixel_x     = pix_x_q;
  assign o_pixel_y     = pix_y_q;
  assign o_pixel_color = pix_color_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: a 640x480 and a 4x3 instance share the requester inputs.
module tb_fb_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_big, start_small;
  logic [31:0] clr_color;
  logic [1:0]  valid;
  logic [19:0] rx, ry;
  logic [63:0] rc;

  logic [1:0]  d_rdy  [2];
  logic        d_we   [2];
  logic [9:0]  d_x    [2];
  logic [9:0]  d_y    [2];
  logic [31:0] d_col  [2];
  logic        d_busy [2];
  logic        d_done [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fb_write_scheduler #(
    .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .COLOR_WIDTH(32), .NUM_REQ(2)
  ) dut_big (
    .clk(clk), .rst(rst), .i_clear_start(start_big), .i_clear_color(clr_color),
    .o_clear_busy(d_busy[0]), .o_clear_done(d_done[0]), .i_req_valid(valid),
    .i_req_x(rx), .i_req_y(ry), .i_req_color(rc), .o_req_ready(d_rdy[0]),
    .o_pixel_we(d_we[0]), .o_pixel_x(d_x[0]), .o_pixel_y(d_y[0]), .o_pixel_color(d_col[0])
  );

  fb_write_scheduler #(
    .SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .COLOR_WIDTH(32), .NUM_REQ(2)
  ) dut_small (
    .clk(clk), .rst(rst), .i_clear_start(start_small), .i_clear_color(clr_color),
    .o_clear_busy(d_busy[1]), .o_clear_done(d_done[1]), .i_req_valid(valid),
    .i_req_x(rx), .i_req_y(ry), .i_req_color(rc), .o_req_ready(d_rdy[1]),
    .o_pixel_we(d_we[1]), .o_pixel_x(d_x[1]), .o_pixel_y(d_y[1]), .o_pixel_color(d_col[1])
  );

  task automatic chk(input string name, input int inst, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h expected=%0h", name, inst, act, exp);
    end
  endtask

  // Model: clear is a pixel index walking 0..W*H-1; requests are picked by scanning from the pointer.
  int          m_ptr [2], m_idx [2], m_x [2], m_y [2];
  logic [31:0] m_col [2], m_ccol [2];
  bit          m_clear [2], m_we [2], m_done [2];

  function automatic int mw(int i); return (i == 0) ? 640 : 4; endfunction
  function automatic int mh(int i); return (i == 0) ? 480 : 3; endfunction

  function automatic int m_grant(int i);
    logic st;
    st = (i == 0) ? start_big : start_small;
    if (m_clear[i] || st) return -1;
    for (int k = 0; k < 2; k++) begin
      int j;
      j = (m_ptr[i] + k) % 2;
      if (valid[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_idx[i] = 0; m_x[i] = 0; m_y[i] = 0; m_col[i] = '0; m_ccol[i] = '0;
      m_clear[i] = 1'b0; m_we[i] = 1'b0; m_done[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int g, qx, qy;
      logic st;
      g  = m_grant(i);
      st = (i == 0) ? start_big : start_small;
      qx = (g >= 0) ? int'(rx[10*g +: 10]) : 0;
      qy = (g >= 0) ? int'(ry[10*g +: 10]) : 0;
      if (rst) begin
        m_clear[i] <= 1'b0; m_ptr[i] <= 0; m_we[i] <= 1'b0; m_done[i] <= 1'b0;
        m_x[i] <= 0; m_y[i] <= 0; m_col[i] <= '0; m_idx[i] <= 0;
      end else begin
        m_we[i]   <= 1'b0;
        m_done[i] <= 1'b0;
        if (m_clear[i]) begin
          m_we[i]  <= 1'b1;
          m_x[i]   <= m_idx[i] % mw(i);
          m_y[i]   <= m_idx[i] / mw(i);
          m_col[i] <= m_ccol[i];
          if (m_idx[i] == mw(i) * mh(i) - 1) begin
            m_done[i]  <= 1'b1;
            m_clear[i] <= 1'b0;
          end else begin
            m_idx[i] <= m_idx[i] + 1;
          end
        end else if (st) begin
          m_clear[i] <= 1'b1;
          m_idx[i]   <= 0;
          m_ccol[i]  <= clr_color;
        end else if (g >= 0) begin
          m_ptr[i] <= (g + 1) % 2;
          if (qx < mw(i) && qy < mh(i)) begin
            m_we[i]  <= 1'b1;
            m_x[i]   <= qx;
            m_y[i]   <= qy;
            m_col[i] <= rc[32*g +: 32];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int g;
        logic [1:0] er;
        g  = m_grant(i);
        er = (g < 0) ? 2'b00 : (2'b01 << g);
        chk("model_ready", i, 64'(d_rdy[i]), 64'(er));
        chk("model_we", i, 64'(d_we[i]), 64'(m_we[i]));
        chk("model_x", i, 64'(d_x[i]), 64'(m_x[i]));
        chk("model_y", i, 64'(d_y[i]), 64'(m_y[i]));
        chk("model_color", i, 64'(d_col[i]), 64'(m_col[i]));
        chk("model_busy", i, 64'(d_busy[i]), 64'(m_clear[i]));
        chk("model_done", i, 64'(d_done[i]), 64'(m_done[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int x, input int y, input logic [31:0] c);
    rx[10*k +: 10] = 10'(x);
    ry[10*k +: 10] = 10'(y);
    rc[32*k +: 32] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog inst=0 got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int dn;
    rst = 1'b1; start_big = 1'b0; start_small = 1'b0; clr_color = '0;
    valid = '0; rx = '0; ry = '0; rc = '0;
    cyc(); cyc();
    chk_en = 1'b1;
    rst = 1'b0;
    #1;
    chk("rst_busy", 1, 64'(d_busy[1]), 64'd0);
    chk("rst_we", 1, 64'(d_we[1]), 64'd0);
    chk("rst_x", 0, 64'(d_x[0]), 64'd0);
    chk("rst_ready", 0, 64'(d_rdy[0]), 64'd0);

    // Single write from requester 0.
    set_req(0, 5, 7, 32'hDEADBEEF);
    valid = 2'b01;
    #1 chk("single_ready", 0, 64'(d_rdy[0]), 64'h1);
    cyc();
    valid = 2'b00;
    chk("single_we", 0, 64'(d_we[0]), 64'h1);
    chk("single_x", 0, 64'(d_x[0]), 64'd5);
    chk("single_y", 0, 64'(d_y[0]), 64'd7);
    chk("single_color", 0, 64'(d_col[0]), 64'hDEADBEEF);
    chk("single_small_drop", 1, 64'(d_we[1]), 64'h0);
    cyc();
    chk("idle_we", 0, 64'(d_we[0]), 64'h0);
    chk("idle_hold_x", 0, 64'(d_x[0]), 64'd5);

    // Both requesters valid: grants alternate from pointer 0.
    rst = 1'b1; cyc(); rst = 1'b0;
    set_req(0, 1, 2, 32'h11);
    set_req(1, 3, 1, 32'h22);
    valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_ready", 0, 64'(d_rdy[0]), (k % 2 == 1) ? 64'h2 : 64'h1);
      cyc();
      chk("rr_we", 0, 64'(d_we[0]), 64'h1);
      chk("rr_color", 0, 64'(d_col[0]), (k % 2 == 1) ? 64'h22 : 64'h11);
    end
    valid = 2'b00;
    cyc();
    chk("rr_end_we", 0, 64'(d_we[0]), 64'h0);

    // Clear sweep on the 4x3 instance.
    clr_color = 32'h00FF00FF;
    start_small = 1'b1;
    cyc();
    start_small = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      chk("clr_busy", 1, 64'(d_busy[1]), (k <= 12) ? 64'h1 : 64'h0);
      chk("clr_done", 1, 64'(d_done[1]), (k == 13) ? 64'h1 : 64'h0);
      chk("clr_we", 1, 64'(d_we[1]), (k >= 2 && k <= 13) ? 64'h1 : 64'h0);
      if (k >= 2 && k <= 13) begin
        chk("clr_x", 1, 64'(d_x[1]), 64'((k - 2) % 4));
        chk("clr_y", 1, 64'(d_y[1]), 64'((k - 2) / 4));
        chk("clr_color", 1, 64'(d_col[1]), 64'h00FF00FF);
      end
      cyc();
    end

    // Clear start against valid requesters, with a second start mid-sweep.
    clr_color = 32'h0000ABCD;
    valid = 2'b11;
    start_small = 1'b1;
    #1 chk("blk_ready_t0", 1, 64'(d_rdy[1]), 64'h0);
    cyc();
    dn = 0;
    for (int k = 1; k <= 16; k++) begin
      start_small = (k == 6);
      #1;
      if (k <= 12) chk("blk_ready", 1, 64'(d_rdy[1]), 64'h0);
      if (k == 13) chk("blk_resume", 1, 64'(d_rdy[1]), 64'h1);
      chk("blk_busy", 1, 64'(d_busy[1]), (k <= 12) ? 64'h1 : 64'h0);
      if (d_done[1]) dn++;
      cyc();
    end
    start_small = 1'b0;
    valid = 2'b00;
    chk("blk_done_count", 1, 64'(dn), 64'd1);
    cyc();

    // Reset in the middle of a sweep.
    start_small = 1'b1;
    cyc();
    start_small = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_busy", 1, 64'(d_busy[1]), 64'h0);
    chk("abort_we", 1, 64'(d_we[1]), 64'h0);
    chk("abort_x", 1, 64'(d_x[1]), 64'h0);
    chk("abort_color", 1, 64'(d_col[1]), 64'h0);
    chk("abort_done", 1, 64'(d_done[1]), 64'h0);
    set_req(0, 2, 1, 32'h77);
    valid = 2'b01;
    #1 chk("abort_ready", 1, 64'(d_rdy[1]), 64'h1);
    cyc();
    valid = 2'b00;
    chk("abort_req_we", 1, 64'(d_we[1]), 64'h1);
    chk("abort_req_x", 1, 64'(d_x[1]), 64'd2);
    dn = 0;
    for (int k = 0; k < 14; k++) begin
      if (d_done[1]) dn++;
      cyc();
    end
    chk("abort_no_done", 1, 64'(dn), 64'd0);

    // Off-screen request on the 640x480 instance.
    set_req(1, 9, 9, 32'h99);
    valid = 2'b10;
    #1 chk("oor_pre_ready", 0, 64'(d_rdy[0]), 64'h2);
    cyc();
    set_req(0, 640, 0, 32'h66);
    valid = 2'b01;
    #1 chk("oor_ready", 0, 64'(d_rdy[0]), 64'h1);
    cyc();
    chk("oor_we", 0, 64'(d_we[0]), 64'h0);
    chk("oor_hold_x", 0, 64'(d_x[0]), 64'd9);
    chk("oor_hold_color", 0, 64'(d_col[0]), 64'h99);
    valid = 2'b11;
    #1 chk("oor_ptr_adv", 0, 64'(d_rdy[0]), 64'h2);
    cyc();
    valid = 2'b00;
    cyc(); cyc();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
